quad_dir_decoder: RTL



---
 rtl/quad_dir_decoder_if.sv | 30 +++
 rtl/quad_dir_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/quad_dir_decoder_if.sv
// Quadrature decoder bus: async phase inputs toward the decoder and the
// decoded counter-control / status outputs back from it.
//   a_in, b_in : quadrature phases (async to clk)
//   cnt_en     : one-cycle step pulse
//   up_down    : direction level, 1=up 0=down
//   err        : one-cycle illegal-transition pulse
//   err_cnt    : saturating illegal-transition count
//   phase      : decoded phase {A,B}
// master = stimulus/consumer side, slave = decoder side.
interface quad_dir_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  logic             a_in;
  logic             b_in;
  logic             cnt_en;
  logic             up_down;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       phase;

  modport master (
    output a_in, b_in,
    input  cnt_en, up_down, err, err_cnt, phase
  );

  modport slave (
    input  a_in, b_in,
    output cnt_en, up_down, err, err_cnt, phase
  );
endinterface

// File: rtl/quad_dir_decoder.sv
// Quadrature direction decoder: synchronises and glitch-filters async A/B
// phases, tracks the Gray-coded phase in a 4-state FSM and emits the
// up_down level and cnt_en step pulse for a downstream up/down counter.
// Illegal (double-bit) phase jumps raise a one-cycle err pulse and bump a
// saturating error counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : quad_dir_decoder_if.slave (a_in/b_in in; cnt_en, up_down,
//                err, err_cnt, phase out; all outputs registered)
// Build option: define QDEC_X4_EN for x4 resolution (cnt_en on every step);
// default x1 pulses cnt_en only on steps entering phase 00.
module quad_dir_decoder #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  quad_dir_decoder_if.slave   bus
);

  localparam int unsigned FC_W     = 4;
  localparam int unsigned INIT_LEN = FILT_LEN + 2;
  localparam int unsigned IC_W     = 5;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } state_t;

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d;
  logic [FC_W-1:0]  fcnt_q [2];
  logic [FC_W-1:0]  fcnt_d [2];
  logic [IC_W-1:0]  stab_q, stab_d;
  logic             init_q, init_d;
  state_t           state_q, state_d;
  state_t           fwd_nxt, rev_nxt;
  logic             cnt_en_q, cnt_en_d;
  logic             up_down_q, up_down_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // State register: synchroniser, filter, init tracking, FSM and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      filt_q    <= 2'b00;
      fcnt_q    <= '{default: '0};
      stab_q    <= '0;
      init_q    <= 1'b0;
      state_q   <= S00;
      cnt_en_q  <= 1'b0;
      up_down_q <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sync1_q   <= {bus.a_in, bus.b_in};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      stab_q    <= stab_d;
      init_q    <= init_d;
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      up_down_q <= up_down_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state: filter, init load, phase FSM
  always_comb begin
    filt_d    = filt_q;
    fcnt_d    = fcnt_q;
    stab_d    = stab_q;
    init_d    = init_q;
    state_d   = state_q;
    cnt_en_d  = 1'b0;
    up_down_d = up_down_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    fwd_nxt   = S01;
    rev_nxt   = S10;

    // Per-bit filter: accept a new value after FILT_LEN consecutive differing clocks
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FC_W'(1);
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end

    // Gray-code neighbours of the current phase
    case (state_q)
      S00: begin fwd_nxt = S01; rev_nxt = S10; end
      S01: begin fwd_nxt = S11; rev_nxt = S00; end
      S11: begin fwd_nxt = S10; rev_nxt = S01; end
      S10: begin fwd_nxt = S00; rev_nxt = S11; end
      default: begin fwd_nxt = S01; rev_nxt = S10; end
    endcase

    if (!init_q) begin
      // Wait out the synchroniser fill plus FILT_LEN quiet clocks, then adopt
      // the filtered phase silently so a non-zero idle level is not a step.
      if (sync2_q == filt_q) begin
        if (stab_q == IC_W'(INIT_LEN - 1)) begin
          init_d  = 1'b1;
          state_d = state_t'(filt_q);
          stab_d  = '0;
        end else begin
          stab_d = stab_q + IC_W'(1);
        end
      end else begin
        stab_d = '0;
      end
    end else if (filt_q != state_q) begin
      state_d = state_t'(filt_q);
      if ((filt_q == fwd_nxt) || (filt_q == rev_nxt)) begin
        up_down_d = (filt_q == fwd_nxt);
`ifdef QDEC_X4_EN
        cnt_en_d = 1'b1;
`else
        cnt_en_d = (filt_q == 2'b00);
`endif
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
    end
  end

  assign bus.cnt_en  = cnt_en_q;
  assign bus.up_down = up_down_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.phase   = state_q;

endmodule
